iterative_wide_mul: RTL and testbench



---
 rtl/iterative_wide_mul.sv | 132 +++++++++++++
 tb/tb_iterative_wide_mul.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_wide_mul.sv
`timescale 1ns/1ps
// Sequential wide multiplier: one A_WIDTH x CHUNK_WIDTH partial product per cycle,
// accumulated modulo 2^OUT_WIDTH, with signed/unsigned mode and valid/ready handshakes.
module iterative_wide_mul #(
    parameter int A_WIDTH     = 16,
    parameter int B_WIDTH     = 32,
    parameter int OUT_WIDTH   = 32,
    parameter int CHUNK_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out
);

    localparam int NUM_CHUNKS = (B_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int CNT_W      = $clog2(NUM_CHUNKS) + 1;
    localparam int PAD_W      = NUM_CHUNKS * CHUNK_WIDTH;
    localparam int PP_W       = A_WIDTH + CHUNK_WIDTH + 2;
    localparam int EXT_W      = (PP_W > OUT_WIDTH) ? PP_W : OUT_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [OUT_WIDTH-1:0]   r_acc;
    logic [OUT_WIDTH-1:0]   r_out;
    logic [A_WIDTH:0]       r_a_ext;
    logic [PAD_W-1:0]       r_b_pad;
    logic                   r_signed;

    logic [PAD_W-1:0]       w_b_pad;
    logic [31:0]            w_shift;
    logic [CHUNK_WIDTH-1:0] w_chunk;
    logic                   w_chunk_msb;
    logic signed [A_WIDTH:0]     w_a_s;
    logic signed [CHUNK_WIDTH:0] w_chunk_s;
    logic signed [PP_W-1:0]      w_pp;
    logic [OUT_WIDTH-1:0]   w_pp_mod;
    logic [OUT_WIDTH-1:0]   w_sum;
    logic                   w_last;

    // b is widened to a whole number of chunks so the top chunk carries the sign padding.
    always_comb begin
        if (is_signed) begin
            w_b_pad = PAD_W'($signed(b));
        end else begin
            w_b_pad = PAD_W'(b);
        end
    end

    assign w_last      = (r_cnt == LAST_CHUNK);
    assign w_shift     = 32'(r_cnt) * 32'(CHUNK_WIDTH);
    assign w_chunk     = CHUNK_WIDTH'(r_b_pad >> w_shift);
    assign w_chunk_msb = r_signed && w_last && w_chunk[CHUNK_WIDTH-1];
    assign w_a_s       = r_a_ext;
    assign w_chunk_s   = {w_chunk_msb, w_chunk};

    // Exact signed (A+1)x(C+1) product, then shifted into place; bits beyond OUT_WIDTH drop off.
    assign w_pp     = PP_W'(w_a_s) * PP_W'(w_chunk_s);
    assign w_pp_mod = OUT_WIDTH'(EXT_W'(w_pp) << w_shift);
    assign w_sum    = r_acc + w_pp_mod;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: always_comb assigns a default before the case so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_MUL;
            S_MUL:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_out <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_MUL: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) r_out <= w_sum;
                end
                default: ;
            endcase
        end
    end

    // NOTE: captured operands carry no reset; they are always reloaded before use, so they stay plain enables.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && in_valid && !rst) begin
            r_a_ext  <= {is_signed & a[A_WIDTH-1], a};
            r_b_pad  <= w_b_pad;
            r_signed <= is_signed;
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;

endmodule

// File: tb/tb_iterative_wide_mul.sv
`timescale 1ns/1ps
// Bench for iterative_wide_mul: default instance plus a 40-bit/56-bit padded-chunk variant,
// checked every cycle against an exact-product reference model.
module tb_iterative_wide_mul;

    localparam int NCH0 = 2;
    localparam int NCH1 = 3;

    logic clk;
    logic rst;

    logic        iv0, ir0, s0, ov0, ordy0;
    logic [15:0] a0;
    logic [31:0] b0;
    logic [31:0] out0;

    logic        iv1, ir1, s1, ov1, ordy1;
    logic [15:0] a1;
    logic [39:0] b1;
    logic [55:0] out1;

    int n_checks = 0;
    int n_fail   = 0;
    int tcyc     = 0;
    int acc_t0   = 0;

    iterative_wide_mul dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .is_signed(s0), .out_valid(ov0), .out_ready(ordy0), .out(out0)
    );

    iterative_wide_mul #(.A_WIDTH(16), .B_WIDTH(40), .OUT_WIDTH(56), .CHUNK_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .is_signed(s1), .out_valid(ov1), .out_ready(ordy1), .out(out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) tcyc++;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Exact product of the extended operands, reduced to ow bits.
    function automatic logic [127:0] model(input logic [63:0] ma, input int aw,
                                           input logic [63:0] mb, input int bw,
                                           input logic ms, input int ow);
        logic [127:0] ax, bx, p;
        ax = 128'(ma);
        bx = 128'(mb);
        if (ms && ma[aw-1]) ax = ax | (~128'd0 << aw);
        if (ms && mb[bw-1]) bx = bx | (~128'd0 << bw);
        p = ax * bx;
        return p & ~(~128'd0 << ow);
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] m;
        logic [63:0] r;
        m = (64'd1 << w) - 64'd1;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1:       return m;
            2:       return 64'd1 << (w - 1);
            3:       return (64'd1 << (w - 1)) - 64'd1;
            default: return r & m;
        endcase
    endfunction

    // Reference state per instance: busy from acceptance until the result handshake.
    logic         armed[2], busy[2], rst_pend[2];
    int           cyc[2], acc_cyc[2];
    logic [127:0] exp_res[2], model_out[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            armed[k] = 1'b0; busy[k] = 1'b0; rst_pend[k] = 1'b0;
            cyc[k] = 0; acc_cyc[k] = 0; exp_res[k] = '0; model_out[k] = '0;
        end
    end

    task automatic mon_step(input int k, input int nch, input int bw, input int ow,
                            input logic rst_s, input logic iv, input logic ir,
                            input logic [63:0] ta, input logic [63:0] tb, input logic ts,
                            input logic ov, input logic ordy, input logic [127:0] o);
        logic ev;
        cyc[k]++;
        if (rst_pend[k]) begin
            busy[k] = 1'b0; model_out[k] = '0; armed[k] = 1'b1; rst_pend[k] = 1'b0;
        end
        ev = busy[k] && (cyc[k] - acc_cyc[k] >= nch + 1);
        if (armed[k]) begin
            if (busy[k] && (cyc[k] - acc_cyc[k] == nch + 1)) model_out[k] = exp_res[k];
            check($sformatf("dut%0d_in_ready", k), ir, !busy[k] && !rst_s);
            check($sformatf("dut%0d_out_valid", k), ov, ev);
            check($sformatf("dut%0d_out", k), o, model_out[k]);
        end
        if (rst_s) begin
            rst_pend[k] = 1'b1;
        end else if (armed[k]) begin
            if (!busy[k] && iv) begin
                busy[k] = 1'b1;
                acc_cyc[k] = cyc[k];
                exp_res[k] = model(ta, 16, tb, bw, ts, ow);
            end else if (ev && ordy) begin
                busy[k] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, NCH0, 32, 32, rst, iv0, ir0, 64'(a0), 64'(b0), s0, ov0, ordy0, 128'(out0));
        mon_step(1, NCH1, 40, 56, rst, iv1, ir1, 64'(a1), 64'(b1), s1, ov1, ordy1, 128'(out1));
    end

    task automatic send0(input logic [15:0] ta, input logic [31:0] tb, input logic ts);
        int n;
        n = 0;
        a0 = ta; b0 = tb; s0 = ts; iv0 = 1'b1;
        @(negedge clk);
        while (!ir0 && n < 200) begin n++; @(negedge clk); end
        check("send0_accept", ir0, 1'b1);
        @(posedge clk); #1;
        iv0 = 1'b0;
        acc_t0 = tcyc;
    endtask

    task automatic send1(input logic [15:0] ta, input logic [39:0] tb, input logic ts);
        int n;
        n = 0;
        a1 = ta; b1 = tb; s1 = ts; iv1 = 1'b1;
        @(negedge clk);
        while (!ir1 && n < 200) begin n++; @(negedge clk); end
        check("send1_accept", ir1, 1'b1);
        @(posedge clk); #1;
        iv1 = 1'b0;
    endtask

    // Returns the result and how many falling edges after acceptance it first appeared.
    task automatic wait_res0(output logic [31:0] r, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!ov0 && n < 200);
        check("wait0_valid", ov0, 1'b1);
        r = out0;
        @(posedge clk); #1;
    endtask

    task automatic wait_res1(output logic [55:0] r, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!ov1 && n < 200);
        check("wait1_valid", ov1, 1'b1);
        r = out1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r0;
        logic [55:0] r1;
        int n, t_first;

        rst = 1'b1;
        iv0 = 1'b0; a0 = '0; b0 = '0; s0 = 1'b0; ordy0 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0; ordy1 = 1'b1;

        check("model_pin_u", model(64'hFFFF, 16, 64'hFFFF_FFFF, 32, 1'b0, 32), 128'hFFFF_0001);
        check("model_pin_s", model(64'hFFFF, 16, 64'h3, 32, 1'b1, 32), 128'hFFFF_FFFD);
        check("model_pin_w", model(64'h2, 16, 64'hFF_FFFF_FFFF, 40, 1'b1, 56), 128'hFF_FFFF_FFFF_FFFE);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out0", out0, 32'd0);
        check("reset_valid0", ov0, 1'b0);
        check("reset_ready0", ir0, 1'b1);
        @(posedge clk); #1;

        // Unsigned corner and latency
        send0(16'hFFFF, 32'hFFFF_FFFF, 1'b0);
        wait_res0(r0, n);
        check("t1_out", r0, 32'hFFFF_0001);
        check("t1_latency_edges", n - 1, 2);

        // Mode selection
        send0(16'hFFFF, 32'h0000_0003, 1'b1);
        wait_res0(r0, n);
        check("t2_signed", r0, 32'hFFFF_FFFD);
        send0(16'hFFFF, 32'h0000_0003, 1'b0);
        wait_res0(r0, n);
        check("t2_unsigned", r0, 32'h0002_FFFD);

        // Backpressure while new operands are offered
        ordy0 = 1'b0;
        send0(16'd3, 32'd5, 1'b0);
        wait_res0(r0, n);
        check("t3_out", r0, 32'd15);
        for (int i = 0; i < 5; i++) begin
            iv0 = ~iv0; a0 = 16'($urandom()); b0 = $urandom();
            @(negedge clk);
            check("t3_hold_out", out0, 32'd15);
            check("t3_hold_valid", ov0, 1'b1);
            check("t3_hold_ready", ir0, 1'b0);
            @(posedge clk); #1;
        end
        iv0 = 1'b0; ordy0 = 1'b1;
        @(posedge clk); #1;
        ordy0 = 1'b0;
        @(negedge clk);
        check("t3_ready_after", ir0, 1'b1);
        check("t3_valid_after", ov0, 1'b0);
        @(posedge clk); #1;
        ordy0 = 1'b1;

        // Reset in the middle of a multiply
        send0(16'h1234, 32'h0001_0000, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t4_valid", ov0, 1'b0);
        check("t4_out", out0, 32'd0);
        check("t4_ready", ir0, 1'b1);
        @(posedge clk); #1;
        send0(16'd2, 32'd7, 1'b0);
        wait_res0(r0, n);
        check("t4_fresh", r0, 32'd14);

        // Back-to-back throughput
        send0(16'd3, 32'd5, 1'b0);
        t_first = acc_t0;
        send0(16'h1234, 32'h0001_0000, 1'b0);
        check("t5_spacing", acc_t0 - t_first, 4);
        wait_res0(r0, n);
        check("t5_second", r0, 32'h1234_0000);

        // Wide variant with padded top chunk
        send1(16'd2, 40'hFF_FFFF_FFFF, 1'b0);
        wait_res1(r1, n);
        check("t6_unsigned", r1, 56'h1FF_FFFF_FFFE);
        check("t6_latency_edges", n - 1, 3);
        send1(16'd2, 40'hFF_FFFF_FFFF, 1'b1);
        wait_res1(r1, n);
        check("t6_signed", r1, 56'hFF_FFFF_FFFF_FFFE);

        // Random traffic with random stalls and stray in_valid pulses
        repeat (150) begin
            send0(16'(pick(16)), 32'(pick(32)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 6)) begin
                ordy0 = 1'($urandom_range(0, 1));
                iv0 = ($urandom_range(0, 3) == 0);
                a0 = 16'(pick(16)); b0 = 32'(pick(32)); s0 = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            iv0 = 1'b0; ordy0 = 1'b1;
        end
        repeat (60) begin
            send1(16'(pick(16)), 40'(pick(40)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 6)) begin
                ordy1 = 1'($urandom_range(0, 1));
                iv1 = ($urandom_range(0, 3) == 0);
                a1 = 16'(pick(16)); b1 = 40'(pick(40)); s1 = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            iv1 = 1'b0; ordy1 = 1'b1;
        end
        repeat (10) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
